l2_elem_packer: RTL and testbench
=================================

# l2_elem_packer

Upstream stage of the L2-norm AXI-Stream datapath. It accepts one signed 16-bit vector element per AXIS beat and packs four consecutive elements into the 64-bit beat format consumed by the L2-norm accumulator stage. Vectors are delimited by `tlast`. A vector whose length is not a multiple of four is closed with a short, zero-padded final beat whose `tkeep` marks only the valid bytes. All outputs are registered.

## Interface
Parameters:
- `ELEM_W`, default 16: element width in bits. Must be a multiple of 8.
- `LANES`, default 4: elements per output beat. `LANES*ELEM_W` = 64 in the shipped configuration.

Ports:
- `clock`, in, 1: single clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `io_in_tdata`, in, ELEM_W: one element, two's complement.
- `io_in_tvalid`, in, 1: upstream element valid.
- `io_in_tready`, out, 1: element accepted on `tvalid && tready`.
- `io_in_tlast`, in, 1: marks the last element of a vector.
- `io_out_tdata`, out, LANES*ELEM_W: packed beat. Lane k occupies bits [k*ELEM_W +: ELEM_W].
- `io_out_tvalid`, out, 1: packed beat valid.
- `io_out_tready`, in, 1: downstream ready.
- `io_out_tkeep`, out, LANES*ELEM_W/8: byte enables. Each valid lane contributes ELEM_W/8 ones.
- `io_out_tlast`, out, 1: final beat of a vector.
- `io_out_tuser`, out, 1: first beat of a vector.

## Operation
- State:
  - assembly register (LANES-1 lanes plus per-lane valid bits)
  - lane counter `lane` in 0..LANES-1
  - `first` flag, set on reset and after every tlast
  - output register holding data, keep, last, user and valid
- `io_in_tready = !io_out_tvalid || io_out_tready`. This is combinational and does not depend on `io_in_tvalid` or `io_in_tlast`.
- On an accepted element:
  - If `lane < LANES-1` and tlast = 0: store the element in lane `lane`, then `lane <= lane+1`.
  - Otherwise (lane = LANES-1, or tlast = 1), the beat completes:
    - The output register loads the assembled lanes plus the current element in lane `lane`.
    - Lanes above `lane` are forced to 0 and their keep bytes to 0.
    - `tlast` = input tlast.
    - `tuser` = `first`.
  - After a completed beat: `lane <= 0`, and `first <= tlast`.
- The packer never rearranges, drops, or sign-extends elements. Padding lanes are zero, so the downstream sum of squares is unaffected.
- `io_out_tvalid` clears on `io_out_tvalid && io_out_tready` unless a new beat is loaded in the same cycle. In that case it stays at 1 and the register holds the new beat.
- A vector of length L produces ceil(L/LANES) beats. Only the last of them has tlast = 1.
- A zero-length vector cannot occur, since tlast always accompanies an element.

## Timing
- Reset values:
  - `io_out_tvalid` = 0, `io_out_tdata` = 0, `io_out_tkeep` = 0, `io_out_tlast` = 0, `io_out_tuser` = 0
  - `lane` = 0, `first` = 1, assembly register cleared
  - `io_in_tready` = 1 (combinational, from tvalid = 0)
- Latency: the element that completes a beat, accepted at edge N, makes `io_out_tvalid` high after edge N. The beat is visible from cycle N+1.
- Throughput: one element per cycle while downstream keeps `tready` high. No bubbles occur, including back-to-back completions.
- Backpressure:
  - While `io_out_tvalid && !io_out_tready`, `io_in_tready` = 0.
  - All output fields stay stable until the handshake.
  - Partial-lane elements are also stalled. This is a deliberate simplification.
- Simultaneous output drain and beat completion in one cycle: the new beat is loaded and `io_out_tvalid` stays at 1.
- Reset asserted mid-vector: the partial assembly and any pending output beat are discarded, with no output for them. The first element after reset starts a new vector with tuser = 1.
- Lane counter wrap: after lane LANES-1, it returns to 0 with no gap cycle.

## Test plan
- Vector 1,2,3,4 (tlast on 4), out_tready = 1:
  - One beat: tdata = 0x0004_0003_0002_0001, tkeep = 0xFF, tlast = 1, tuser = 1.
  - tvalid rises the cycle after the 4 is accepted.
- Vector of 6 elements 0x8000, 0x7FFF, 1, 2, 3, 0xFFFF:
  - Beat 1: 0x0002_0001_7FFF_8000, keep 0xFF, last 0, user 1.
  - Beat 2: 0x0000_0000_FFFF_0003, keep 0x0F, last 1, user 0.
- Single-element vector 5 (tlast on 5): beat 0x0000_0000_0000_0005, keep 0x03, last 1, user 1.
- Continuous 8-element vector with out_tready held low for 5 cycles after beat 1:
  - `in_tready` = 0 during the stall.
  - Beat 1 stays stable throughout the stall.
  - No elements are lost, and beat 2 follows correctly.
- Two 4-element vectors back to back, out_tready = 1:
  - Two beats on consecutive-beat boundaries.
  - The second beat has tuser = 1 and tlast = 1.
  - tvalid never drops between completions.
- Reset after 3 elements of a vector, then send 7,8 with tlast:
  - No output from the aborted vector.
  - Beat 0x0000_0000_0008_0007, keep 0x0F, last 1, user 1.

Source files
------------

// File: rtl/l2_elem_packer.sv
// l2_elem_packer
//   Packs LANES consecutive signed ELEM_W-bit AXIS elements into one
//   LANES*ELEM_W-bit beat for the L2-norm accumulator stage. Vectors are
//   delimited by tlast. A short final beat is zero-padded, and tkeep marks
//   only the valid bytes.
// Ports:
//   clock, reset                  : rising-edge clock, synchronous active-high reset
//   io_in_tdata/tvalid/tready/tlast : element input stream
//   io_out_tdata/tvalid/tready    : packed beat output stream
//   io_out_tkeep                  : byte enables, ELEM_W/8 bits per valid lane
//   io_out_tlast                  : final beat of a vector
//   io_out_tuser                  : first beat of a vector
module l2_elem_packer #(
  parameter int ELEM_W = 16,
  parameter int LANES  = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [ELEM_W-1:0]           io_in_tdata,
  input  logic                        io_in_tvalid,
  output logic                        io_in_tready,
  input  logic                        io_in_tlast,
  output logic [LANES*ELEM_W-1:0]     io_out_tdata,
  output logic                        io_out_tvalid,
  input  logic                        io_out_tready,
  output logic [LANES*ELEM_W/8-1:0]   io_out_tkeep,
  output logic                        io_out_tlast,
  output logic                        io_out_tuser
);

  localparam int DATA_W = LANES * ELEM_W;
  localparam int KEEP_W = DATA_W / 8;
  localparam int BPL    = ELEM_W / 8;
  localparam int LANE_W = (LANES > 2) ? $clog2(LANES) : 1;
  localparam int ASM_W  = (LANES - 1) * ELEM_W;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  // Assembly register: lanes 0..LANES-2 plus their valid bits.
  logic [ASM_W-1:0]  asm_data_r;
  logic [LANES-2:0]  asm_vld_r;
  logic [LANE_W-1:0] lane_r;
  logic              first_r;

  // Output register.
  logic [DATA_W-1:0] out_data_r;
  logic [KEEP_W-1:0] out_keep_r;
  logic              out_last_r;
  logic              out_user_r;
  logic              out_valid_r;

  logic              in_ready_s;
  logic              accept_s;
  logic              complete_s;
  logic [DATA_W-1:0] asm_ext_s;
  logic [LANES-1:0]  asm_vld_ext_s;
  logic [DATA_W-1:0] beat_data_s;
  logic [KEEP_W-1:0] beat_keep_s;

  // Input may be taken whenever the output register is empty or draining.
  assign in_ready_s = !out_valid_r || io_out_tready;
  assign accept_s   = io_in_tvalid && in_ready_s;
  assign complete_s = accept_s && ((lane_r == LAST_LANE) || io_in_tlast);

  // The top lane never lives in the assembly register. Widening the
  // register to full beat width keeps the lane loop below uniform.
  assign asm_ext_s     = {{ELEM_W{1'b0}}, asm_data_r};
  assign asm_vld_ext_s = {1'b0, asm_vld_r};

  // Build the candidate beat: stored lanes, the current element in lane
  // `lane`, and zero data and keep in every lane above it.
  always_comb begin
    beat_data_s = {DATA_W{1'b0}};
    beat_keep_s = {KEEP_W{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      if (LANE_W'(k) == lane_r) begin
        beat_data_s[k*ELEM_W +: ELEM_W] = io_in_tdata;
        beat_keep_s[k*BPL +: BPL]       = {BPL{1'b1}};
      end else if (asm_vld_ext_s[k]) begin
        beat_data_s[k*ELEM_W +: ELEM_W] = asm_ext_s[k*ELEM_W +: ELEM_W];
        beat_keep_s[k*BPL +: BPL]       = {BPL{1'b1}};
      end else begin
        beat_data_s[k*ELEM_W +: ELEM_W] = {ELEM_W{1'b0}};
        beat_keep_s[k*BPL +: BPL]       = {BPL{1'b0}};
      end
    end
  end

  // Assembly, lane counter, first flag and output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      asm_data_r  <= {ASM_W{1'b0}};
      asm_vld_r   <= {(LANES-1){1'b0}};
      lane_r      <= {LANE_W{1'b0}};
      first_r     <= 1'b1;
      out_data_r  <= {DATA_W{1'b0}};
      out_keep_r  <= {KEEP_W{1'b0}};
      out_last_r  <= 1'b0;
      out_user_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      if (complete_s) begin
        // A load in the same cycle as a drain keeps tvalid high.
        out_data_r  <= beat_data_s;
        out_keep_r  <= beat_keep_s;
        out_last_r  <= io_in_tlast;
        out_user_r  <= first_r;
        out_valid_r <= 1'b1;
        lane_r      <= {LANE_W{1'b0}};
        first_r     <= io_in_tlast;
        asm_vld_r   <= {(LANES-1){1'b0}};
      end else begin
        if (out_valid_r && io_out_tready) begin
          out_valid_r <= 1'b0;
        end
        if (accept_s) begin
          for (int k = 0; k < LANES - 1; k++) begin
            if (LANE_W'(k) == lane_r) begin
              asm_data_r[k*ELEM_W +: ELEM_W] <= io_in_tdata;
              asm_vld_r[k]                   <= 1'b1;
            end
          end
          lane_r <= lane_r + LANE_W'(1);
        end
      end
    end
  end

  assign io_in_tready  = in_ready_s;
  assign io_out_tdata  = out_data_r;
  assign io_out_tkeep  = out_keep_r;
  assign io_out_tlast  = out_last_r;
  assign io_out_tuser  = out_user_r;
  assign io_out_tvalid = out_valid_r;

endmodule

// File: tb/tb_l2_elem_packer.sv
// Scoreboard bench for l2_elem_packer (ELEM_W=16, LANES=4).
// Stimulus pushes hand-computed beats into a queue. A negedge monitor pops
// and compares on every output handshake.
module tb_l2_elem_packer;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  logic        clock;
  logic        reset;
  logic [15:0] in_tdata;
  logic        in_tvalid;
  logic        in_tready;
  logic        in_tlast;
  logic [63:0] out_tdata;
  logic        out_tvalid;
  logic        out_tready;
  logic [7:0]  out_tkeep;
  logic        out_tlast;
  logic        out_tuser;

  int    errors = 0;
  int    checks = 0;
  int    cyc    = 0;
  beat_t exp_q[$];

  l2_elem_packer #(.ELEM_W(16), .LANES(4)) dut (
    .clock(clock), .reset(reset),
    .io_in_tdata(in_tdata), .io_in_tvalid(in_tvalid),
    .io_in_tready(in_tready), .io_in_tlast(in_tlast),
    .io_out_tdata(out_tdata), .io_out_tvalid(out_tvalid),
    .io_out_tready(out_tready), .io_out_tkeep(out_tkeep),
    .io_out_tlast(out_tlast), .io_out_tuser(out_tuser)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every handshake must match the oldest expected beat.
  always @(negedge clock) begin
    if (!reset && out_tvalid && out_tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got d=%h k=%h l=%b u=%b expected none",
                 out_tdata, out_tkeep, out_tlast, out_tuser);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        if (out_tdata !== e.d || out_tkeep !== e.k || out_tlast !== e.l || out_tuser !== e.u) begin
          errors++;
          $display("FAIL beat: got d=%h k=%h l=%b u=%b expected d=%h k=%h l=%b u=%b",
                   out_tdata, out_tkeep, out_tlast, out_tuser, e.d, e.k, e.l, e.u);
        end
      end
    end
  end

  // Present one element and hold it until accepted; returns 1 ns after the
  // accepting edge.
  task automatic send(input logic [15:0] d, input logic last);
    logic ok;
    int   n;
    in_tdata  = d;
    in_tlast  = last;
    in_tvalid = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      @(negedge clock);
      ok = in_tready;
      @(posedge clock);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_tready=0 expected 1 within 50 cycles");
    end
  endtask

  task automatic idle();
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    in_tdata  = 16'h0000;
  endtask

  task automatic push(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    beat_t b;
    b.d = d; b.k = k; b.l = l; b.u = u;
    exp_q.push_back(b);
  endtask

  initial begin
    int start;
    int n;
    reset      = 1'b1;
    out_tready = 1'b1;
    idle();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state.
    @(negedge clock);
    check("rst_tvalid", {63'd0, out_tvalid}, 64'd0);
    check("rst_tdata",  out_tdata, 64'd0);
    check("rst_tkeep",  {56'd0, out_tkeep}, 64'd0);
    check("rst_tlast",  {63'd0, out_tlast}, 64'd0);
    check("rst_tuser",  {63'd0, out_tuser}, 64'd0);
    check("rst_in_tready", {63'd0, in_tready}, 64'd1);
    @(posedge clock);
    #1;

    // 1,2,3,4: tvalid rises right after the 4 is accepted.
    push(64'h0004_0003_0002_0001, 8'hFF, 1'b1, 1'b1);
    send(16'd1, 1'b0); send(16'd2, 1'b0); send(16'd3, 1'b0);
    check("lat_before", {63'd0, out_tvalid}, 64'd0);
    send(16'd4, 1'b1);
    check("lat_after", {63'd0, out_tvalid}, 64'd1);
    idle();

    // Six elements: full beat then padded beat.
    push(64'h0002_0001_7FFF_8000, 8'hFF, 1'b0, 1'b1);
    push(64'h0000_0000_FFFF_0003, 8'h0F, 1'b1, 1'b0);
    send(16'h8000, 1'b0); send(16'h7FFF, 1'b0); send(16'h0001, 1'b0);
    send(16'h0002, 1'b0); send(16'h0003, 1'b0); send(16'hFFFF, 1'b1);
    idle();

    // Single-element vector.
    push(64'h0000_0000_0000_0005, 8'h03, 1'b1, 1'b1);
    send(16'd5, 1'b1);
    idle();
    @(posedge clock);
    #1;

    // Eight elements with a 5-cycle stall after beat 1.
    push(64'h0014_0013_0012_0011, 8'hFF, 1'b0, 1'b1);
    push(64'h0018_0017_0016_0015, 8'hFF, 1'b1, 1'b0);
    out_tready = 1'b0;
    send(16'h0011, 1'b0); send(16'h0012, 1'b0); send(16'h0013, 1'b0); send(16'h0014, 1'b0);
    in_tdata  = 16'h0015;
    in_tlast  = 1'b0;
    in_tvalid = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("stall_in_tready", {63'd0, in_tready}, 64'd0);
      check("stall_tvalid", {63'd0, out_tvalid}, 64'd1);
      check("stall_tdata", out_tdata, 64'h0014_0013_0012_0011);
    end
    @(posedge clock);
    #1;
    out_tready = 1'b1;
    send(16'h0015, 1'b0); send(16'h0016, 1'b0); send(16'h0017, 1'b0); send(16'h0018, 1'b1);
    idle();

    // Two 4-element vectors back to back: eight elements in eight cycles.
    push(64'h00A4_00A3_00A2_00A1, 8'hFF, 1'b1, 1'b1);
    push(64'h00B4_00B3_00B2_00B1, 8'hFF, 1'b1, 1'b1);
    start = cyc;
    send(16'h00A1, 1'b0); send(16'h00A2, 1'b0); send(16'h00A3, 1'b0); send(16'h00A4, 1'b1);
    send(16'h00B1, 1'b0); send(16'h00B2, 1'b0); send(16'h00B3, 1'b0); send(16'h00B4, 1'b1);
    check("b2b_cycles", 64'(cyc - start), 64'd8);
    idle();

    // Back-to-back completions: tvalid must not drop.
    push(64'h0000_0000_0000_0101, 8'h03, 1'b1, 1'b1);
    push(64'h0000_0000_0000_0202, 8'h03, 1'b1, 1'b1);
    push(64'h0000_0000_0000_0303, 8'h03, 1'b1, 1'b1);
    send(16'h0101, 1'b1);
    check("b2b_tvalid1", {63'd0, out_tvalid}, 64'd1);
    send(16'h0202, 1'b1);
    check("b2b_tvalid2", {63'd0, out_tvalid}, 64'd1);
    send(16'h0303, 1'b1);
    check("b2b_tvalid3", {63'd0, out_tvalid}, 64'd1);
    idle();
    @(posedge clock);
    #1;

    // Reset mid-vector, then 7,8.
    send(16'h0031, 1'b0); send(16'h0032, 1'b0); send(16'h0033, 1'b0);
    idle();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("midrst_tvalid", {63'd0, out_tvalid}, 64'd0);
    push(64'h0000_0000_0008_0007, 8'h0F, 1'b1, 1'b1);
    send(16'd7, 1'b0); send(16'd8, 1'b1);
    idle();

    // Drain.
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clock);
      n++;
    end
    @(negedge clock);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
